col_dispatch_sched: RTL and testbench

COL_DISPATCH_SCHED -- requirements
Module: col_dispatch_sched

---
 rtl/col_dispatch_sched.sv | 163 ++++++++++++++++
 tb/tb_col_dispatch_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/col_dispatch_sched.sv
// ============================================================================
// Module      : col_dispatch_sched
// Description : Round-robin column dispatcher with signed max reduction of
//               lane results. Optional macro COL_SCHED_CYCLE_CNT_EN adds a
//               run-length counter on cycle_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module col_dispatch_sched #(
    parameter int IMG_COLS  = 4,
    parameter int NUM_LANES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_LANES-1:0]        lane_req,
    output logic [NUM_LANES-1:0]        lane_grant,
    output logic [31:0]                 grant_col,
    input  logic [NUM_LANES-1:0]        lane_done,
    input  logic [NUM_LANES-1:0][31:0]  lane_result,
    output logic                        busy,
    output logic                        complete,
    output logic signed [31:0]          best,
    output logic                        err,
    output logic [31:0]                 cycle_count
);

    localparam int OUT_W = $clog2(IMG_COLS) + 1;
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_next_col;
    logic [OUT_W-1:0]   r_outstanding;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic signed [31:0] r_best;
    logic               r_err;

    logic               w_busy;
    logic               w_start_ok;
    logic [NUM_LANES-1:0] w_grant;
    logic               w_grant_any;
    logic [PTR_W-1:0]   w_ptr_next;
    int                 w_idx;
    int                 w_done_cnt;
    int                 w_avail;
    int                 w_out_next;
    logic               w_done_ok;
    logic               w_done_bad;
    logic signed [31:0] w_best_cand;

    assign w_busy     = (r_state == DISPATCH) || (r_state == DRAIN);
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    // Search begins at the lane after the previous winner.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_ptr_next  = r_rr_ptr;
        w_idx       = 0;
        if (r_state == DISPATCH) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                w_idx = (int'(r_rr_ptr) + k) % NUM_LANES;
                if (!w_grant_any && lane_req[w_idx]) begin
                    w_grant[w_idx] = 1'b1;
                    w_grant_any    = 1'b1;
                    w_ptr_next     = PTR_W'((w_idx + 1) % NUM_LANES);
                end
            end
        end
    end

    // A done vector that would underflow the outstanding count is dropped whole.
    always_comb begin
        w_done_cnt  = 0;
        w_best_cand = r_best;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_done[i]) begin
                w_done_cnt = w_done_cnt + 1;
                if ($signed(lane_result[i]) > w_best_cand) begin
                    w_best_cand = $signed(lane_result[i]);
                end
            end
        end
        w_avail    = int'(r_outstanding) + (w_grant_any ? 1 : 0);
        w_done_bad = (w_done_cnt != 0) && (!w_busy || (w_done_cnt > w_avail));
        w_done_ok  = (w_done_cnt != 0) && !w_done_bad;
        w_out_next = w_done_ok ? (w_avail - w_done_cnt) : w_avail;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (start) w_state_next = DISPATCH;
            DISPATCH: if (w_grant_any && (r_next_col == 32'(IMG_COLS - 1)))
                          w_state_next = DRAIN;
            DRAIN:    if (w_out_next == 0) w_state_next = DONE;
            DONE:     if (start) w_state_next = DISPATCH;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_next_col    <= '0;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
            r_best        <= '0;
            r_err         <= 1'b0;
        end else if (w_start_ok) begin
            r_state       <= w_state_next;
            r_next_col    <= '0;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
            r_best        <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= OUT_W'(w_out_next);
            if (w_grant_any) begin
                r_next_col <= r_next_col + 32'd1;
                r_rr_ptr   <= w_ptr_next;
            end
            if (w_done_ok)  r_best <= w_best_cand;
            if (w_done_bad) r_err  <= 1'b1;
        end
    end

`ifdef COL_SCHED_CYCLE_CNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_cycle_count <= '0;
        end else if (w_busy) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'd0;
`endif

    assign lane_grant = w_grant;
    assign grant_col  = w_grant_any ? r_next_col : 32'd0;
    assign busy       = w_busy;
    assign complete   = (r_state == DONE);
    assign best       = r_best;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_col_dispatch_sched.sv
// ============================================================================
// Module      : tb_col_dispatch_sched
// Description : Directed self-checking bench for col_dispatch_sched
//               (IMG_COLS=4, NUM_LANES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_col_dispatch_sched;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        lane_req = 2'b00;
    logic [1:0]        lane_grant;
    logic [31:0]       grant_col;
    logic [1:0]        lane_done = 2'b00;
    logic [1:0][31:0]  lane_result = '0;
    logic              busy;
    logic              complete;
    logic signed [31:0] best;
    logic              err;
    logic [31:0]       cycle_count;

    int total = 0;
    int bad   = 0;

    col_dispatch_sched #(.IMG_COLS(4), .NUM_LANES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lane_req    (lane_req),
        .lane_grant  (lane_grant),
        .grant_col   (grant_col),
        .lane_done   (lane_done),
        .lane_result (lane_result),
        .busy        (busy),
        .complete    (complete),
        .best        (best),
        .err         (err),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic dispatch_all();
        lane_req = 2'b11;
        repeat (4) step();
        lane_req = 2'b00;
    endtask

    task automatic give_done(input logic [1:0] mask, input int r0, input int r1);
        lane_done      = mask;
        lane_result[0] = r0;
        lane_result[1] = r1;
        step();
        lane_done = 2'b00;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        lane_req = 2'b11;
        step();
        step();
        rst = 1'b0;
        #1;
        total++; if (lane_grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", lane_grant); end
        total++; if (grant_col !== 32'd0) begin bad++; $display("FAIL reset_col got=%0d want=0", grant_col); end
        total++; if (busy !== 1'b0 || complete !== 1'b0) begin bad++; $display("FAIL reset_status busy=%b complete=%b want=0,0", busy, complete); end
        total++; if (best !== 32'sd0 || err !== 1'b0) begin bad++; $display("FAIL reset_best_err best=%0d err=%b want=0,0", best, err); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycle_count); end
        lane_req = 2'b00;
    endtask

    task automatic test_dispatch_rr();
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_start();
        lane_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (lane_grant !== exp_g[k] || grant_col !== 32'(k)) begin
                bad++; $display("FAIL rr_grant%0d got=%b/%0d want=%b/%0d", k, lane_grant, grant_col, exp_g[k], k);
            end
            step();
        end
        lane_req = 2'b00;
        #1;
        total++; if (busy !== 1'b1 || complete !== 1'b0 || lane_grant !== 2'b00) begin
            bad++; $display("FAIL drain_entry busy=%b complete=%b grant=%b want=1,0,00", busy, complete, lane_grant);
        end
    endtask

    task automatic test_results();
        int vals [4];
        logic [1:0] masks [4];
        logic [31:0] held;
        vals  = '{5, -3, 12, 7};
        masks = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            lane_done      = masks[i];
            lane_result[0] = vals[i];
            lane_result[1] = vals[i];
            #1;
            if (i == 3) begin
                total++; if (complete !== 1'b0) begin bad++; $display("FAIL early_complete got=%b want=0", complete); end
            end
            step();
            lane_done = 2'b00;
        end
        #1;
        total++; if (complete !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL results_complete complete=%b busy=%b want=1,0", complete, busy); end
        total++; if (best !== 32'sd12) begin bad++; $display("FAIL results_best got=%0d want=12", best); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL results_err got=%b want=0", err); end
`ifdef COL_SCHED_CYCLE_CNT_EN
        total++; if (cycle_count !== 32'd8) begin bad++; $display("FAIL cycles_run got=%0d want=8", cycle_count); end
`else
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL cycles_off got=%0d want=0", cycle_count); end
`endif
        held = cycle_count;
        step();
        total++; if (complete !== 1'b1 || cycle_count !== held) begin
            bad++; $display("FAIL done_hold complete=%b cycles=%0d want=1,%0d", complete, cycle_count, held);
        end
    endtask

    task automatic test_partial_and_dual();
        do_start();
        lane_req = 2'b10;
        #1;
        total++; if (lane_grant !== 2'b10 || grant_col !== 32'd0) begin bad++; $display("FAIL single_req got=%b/%0d want=10/0", lane_grant, grant_col); end
        step();
        lane_req = 2'b00;
        start    = 1'b1;
        #1;
        total++; if (lane_grant !== 2'b00 || grant_col !== 32'd0) begin bad++; $display("FAIL no_req got=%b/%0d want=00/0", lane_grant, grant_col); end
        step();
        start    = 1'b0;
        lane_req = 2'b11;
        #1;
        total++; if (lane_grant !== 2'b01 || grant_col !== 32'd1) begin bad++; $display("FAIL busy_start_ignored got=%b/%0d want=01/1", lane_grant, grant_col); end
        step();
        #1;
        total++; if (lane_grant !== 2'b10 || grant_col !== 32'd2) begin bad++; $display("FAIL rr_wrap got=%b/%0d want=10/2", lane_grant, grant_col); end
        step();
        lane_req = 2'b01;
        #1;
        total++; if (lane_grant !== 2'b01 || grant_col !== 32'd3) begin bad++; $display("FAIL rr_last got=%b/%0d want=01/3", lane_grant, grant_col); end
        step();
        lane_req = 2'b00;
        give_done(2'b01, 10, 0);
        total++; if (best !== 32'sd10) begin bad++; $display("FAIL best_ten got=%0d want=10", best); end
        give_done(2'b11, 9, 20);
        total++; if (best !== 32'sd20 || complete !== 1'b0) begin bad++; $display("FAIL dual_done best=%0d complete=%b want=20,0", best, complete); end
        give_done(2'b11, 50, 60);
        total++; if (err !== 1'b1 || best !== 32'sd20 || complete !== 1'b0) begin
            bad++; $display("FAIL underflow err=%b best=%0d complete=%b want=1,20,0", err, best, complete);
        end
        give_done(2'b10, 1, 1);
        total++; if (complete !== 1'b1 || err !== 1'b1 || best !== 32'sd20) begin
            bad++; $display("FAIL after_underflow complete=%b err=%b best=%0d want=1,1,20", complete, err, best);
        end
    endtask

    task automatic test_negative();
        do_start();
        total++; if (err !== 1'b0 || best !== 32'sd0 || busy !== 1'b1) begin
            bad++; $display("FAIL restart err=%b best=%0d busy=%b want=0,0,1", err, best, busy);
        end
        dispatch_all();
        give_done(2'b01, -4, 0);
        give_done(2'b10, 0, -1);
        give_done(2'b01, -8, 0);
        give_done(2'b10, 0, -2);
        total++; if (complete !== 1'b1 || best !== 32'sd0) begin bad++; $display("FAIL negative complete=%b best=%0d want=1,0", complete, best); end
    endtask

    task automatic test_idle_done();
        rst = 1'b1;
        step();
        rst = 1'b0;
        give_done(2'b01, 100, 0);
        total++; if (err !== 1'b1 || best !== 32'sd0) begin bad++; $display("FAIL idle_done err=%b best=%0d want=1,0", err, best); end
        do_start();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL start_clears_err got=%b want=0", err); end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_start();
        dispatch_all();
        give_done(2'b01, 3, 0);
        give_done(2'b10, 0, 4);
        total++; if (busy !== 1'b1 || best !== 32'sd4) begin bad++; $display("FAIL pre_rst busy=%b best=%0d want=1,4", busy, best); end
        rst      = 1'b1;
        lane_req = 2'b11;
        step();
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || complete !== 1'b0 || best !== 32'sd0 || err !== 1'b0) begin
            bad++; $display("FAIL mid_rst busy=%b complete=%b best=%0d err=%b want=0,0,0,0", busy, complete, best, err);
        end
        total++; if (lane_grant !== 2'b00 || grant_col !== 32'd0 || cycle_count !== 32'd0) begin
            bad++; $display("FAIL mid_rst_out grant=%b col=%0d cycles=%0d want=00,0,0", lane_grant, grant_col, cycle_count);
        end
        lane_req = 2'b00;
        give_done(2'b01, 7, 0);
        total++; if (err !== 1'b1 || best !== 32'sd0) begin bad++; $display("FAIL stale_done err=%b best=%0d want=1,0", err, best); end
    endtask

    initial begin
        test_reset();
        test_dispatch_rr();
        test_results();
        test_partial_and_dual();
        test_negative();
        test_idle_done();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
